// File: rtl/dtcm_pkg.sv
// dtcm_pkg: shared types and address decode for the DTCM responder
package dtcm_pkg;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_RANGE    = 2'd1,
        ERR_ALIGN    = 2'd2,
        ERR_CONFLICT = 2'd3
    } err_cause_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } resp_state_e;

    // wrap-around below base yields a huge offset and so falls out of range
    function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] bytes);
        logic [31:0] off;
        off = addr - base;
        return (off < bytes) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dtcm_ram.sv
// dtcm_ram: DEPTH_WORDS x 32 storage, async read, registered read, one write port
module dtcm_ram #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic          rd_en,
    input  logic          rd_clr,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    assign rdata = mem[raddr];

    // single write port; contents are never reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // registered read: clear wins, otherwise load on enable and hold
    always_ff @(posedge clk) begin
        if (rd_clr) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dtcm_responder.sv
// dtcm_responder: zero-wait DTCM slave with loader/debug port and access error counting
module dtcm_responder
    import dtcm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dtcm_mem_write,
    input  logic                 dtcm_mem_read,
    input  logic [31:0]          dtcm_addr,
    input  logic [31:0]          dtcm_dataout,
    output logic [31:0]          dtcm_datain,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic                 ld_we,
    input  logic [31:0]          ld_addr,
    input  logic [31:0]          ld_wdata,
    output logic                 ld_rvalid,
    output logic [31:0]          ld_rdata,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] BYTES = 32'(DEPTH_WORDS * 4);

    resp_state_e   state;
    logic [AW-1:0] core_idx, ld_idx;
    logic [31:0]   ram_rdata;
    logic          core_legal, ld_legal, core_err, core_we;
    logic          ld_rd_acc, ld_wr_acc;

    assign core_legal = addr_legal(dtcm_addr, BASE_ADDR, BYTES);
    assign ld_legal   = addr_legal(ld_addr, BASE_ADDR, BYTES);
    assign core_idx   = AW'((dtcm_addr - BASE_ADDR) >> 2);
    assign ld_idx     = AW'((ld_addr - BASE_ADDR) >> 2);

    // both strobes together is illegal even when the address is fine
    assign core_err = (dtcm_mem_read | dtcm_mem_write) & (~core_legal | (dtcm_mem_read & dtcm_mem_write));
    // core stores are not gated by rst so a store coinciding with reset lands
    assign core_we  = dtcm_mem_write & ~dtcm_mem_read & core_legal;

    assign dtcm_datain = (dtcm_mem_read & ~core_err & ~rst) ? ram_rdata : 32'h0;

    // core always wins; loader only proceeds on a cycle with no core strobe
    assign ld_ready  = ld_valid & ~dtcm_mem_read & ~dtcm_mem_write & ~rst;
    assign ld_rd_acc = ld_ready & ~ld_we;
    assign ld_wr_acc = ld_ready & ld_we & ld_legal;
    assign ld_rvalid = (state == S_RESP);

    dtcm_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
        .clk     (clk),
        .we      (core_we | ld_wr_acc),
        .waddr   (core_we ? core_idx : ld_idx),
        .wdata   (core_we ? dtcm_dataout : ld_wdata),
        .raddr   (core_idx),
        .rdata   (ram_rdata),
        .rd_en   (ld_rd_acc),
        .rd_clr  (rst | (ld_rd_acc & ~ld_legal)),
        .rd_addr (ld_idx),
        .rd_data (ld_rdata)
    );

    // loader response FSM: RESP for exactly the cycle after each accepted read
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else state <= ld_rd_acc ? S_RESP : S_IDLE;
    end

    // registered error pulse and saturating error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= core_err;
            if (core_err && err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: doc/dtcm_responder.md
Name: dtcm_responder

Overview:
- Data tightly-coupled memory: the responder end of the core's DTCM master interface (dtcm_mem_write / dtcm_mem_read / dtcm_addr / dtcm_dataout / dtcm_datain).
- Serves zero-wait-state word loads and stores to the core. Also provides a secondary valid/ready loader/debug port for preloading and inspecting data memory.
- Checks core accesses for range and alignment errors and counts them.
- Sits beside the core at SoC top level; DTCM port signals connect one-to-one by name.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words; power of two, minimum 16.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock; every register samples on its rising edge.
- rst  in  1  synchronous reset, active-high.
- dtcm_mem_write  in  1  core store strobe, one cycle per store.
- dtcm_mem_read  in  1  core load strobe.
- dtcm_addr  in  32  core byte address.
- dtcm_dataout  in  32  core store data.
- dtcm_datain  out  32  core load data; combinational.
- ld_valid  in  1  loader request valid.
- ld_ready  out  1  loader request accepted this cycle.
- ld_we  in  1  loader request type: 1 = write, 0 = read.
- ld_addr  in  32  loader byte address.
- ld_wdata  in  32  loader write data.
- ld_rvalid  out  1  loader read data valid; one-cycle pulse.
- ld_rdata  out  32  loader read data.
- err_pulse  out  1  one-cycle pulse per illegal core access.
- err_count  out  ERR_CNT_W  saturating count of illegal core accesses.

Behaviour:
- Address decode: word index = (addr - BASE_ADDR) >> 2. An access is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
- Storage is an array of DEPTH_WORDS x 32 with no reset of contents.
- Core load: dtcm_datain = mem[idx] combinationally in the same cycle dtcm_mem_read is high (zero latency; the core consumes it in EX).
  - dtcm_datain = 0 when dtcm_mem_read is low, the access is illegal, or rst is high.
- Core store: mem[idx] <= dtcm_dataout at the rising edge ending the strobe cycle. A load in the next cycle returns the new value.
- Illegal core access is any of: out of range, addr[1:0] != 0, or read and write strobes high together.
  - The store is suppressed and the load returns 0.
  - err_pulse is registered: high in the cycle after the access.
  - err_count increments and saturates at all-ones.
- Arbitration: the core always wins; the core interface never stalls.
  - ld_ready = ld_valid & ~dtcm_mem_read & ~dtcm_mem_write & ~rst (combinational).
  - The loader holds ld_valid, ld_we, ld_addr and ld_wdata stable until ld_ready.
- Loader write: on acceptance, mem[idx] <= ld_wdata at the same edge.
  - Out-of-range or misaligned loader accesses are accepted and silently dropped.
  - Loader errors do not touch err_count.
- Loader read: on acceptance, ld_rdata <= mem[idx] (0 if illegal) and ld_rvalid <= 1 at that edge, so both are visible the cycle after acceptance. ld_rvalid drops after one cycle unless another read is accepted.
  - Back-to-back reads give one response per cycle.
  - ld_rdata holds its last value while ld_rvalid is low.
- Response FSM, two states:
  - IDLE -> RESP on an accepted loader read.
  - RESP -> RESP on another accepted read; RESP -> IDLE otherwise.
  - ld_rvalid = (state == RESP).
- Reset values: state IDLE, ld_rvalid 0, ld_rdata 0, err_pulse 0, err_count 0. ld_ready and dtcm_datain are forced 0 while rst is high.
- Reset mid-operation: a pending loader read response is discarded; memory contents are preserved; a store whose strobe coincides with rst is still written.
- Address arithmetic is 32-bit unsigned. Subtraction wrap-around below BASE_ADDR counts as out of range.

Decomposition:
- Shared package dtcm_pkg:
  - access-error cause encodings (ERR_RANGE, ERR_ALIGN, ERR_CONFLICT) for bench checkers;
  - response FSM state typedef;
  - helper function for in-range/aligned decode.
- One sub-module, dtcm_ram: a DEPTH_WORDS x 32 array with one asynchronous read port, one registered read port, and one write port. It holds storage only, so it can be swapped for an SRAM macro wrapper.
- Arbitration, decode, error counter and FSM stay in dtcm_responder.

Test Plan:
- Core store 32'hDEAD_BEEF to BASE_ADDR+8, then core load BASE_ADDR+8 next cycle -> dtcm_datain = 32'hDEAD_BEEF in the load cycle; err_pulse stays 0.
- Loader write 32'h1234_5678 to BASE_ADDR+0x40 with core idle -> ld_ready = 1 in the same cycle; core load of BASE_ADDR+0x40 one cycle later returns 32'h1234_5678.
- ld_valid read held while the core loads for 3 consecutive cycles -> ld_ready = 0 for those 3 cycles, then 1; ld_rvalid pulses exactly once the cycle after, with correct data.
- Core load at BASE_ADDR+4*DEPTH_WORDS, then store at BASE_ADDR+2 -> dtcm_datain = 0; err_pulse high on each following cycle; err_count = 2; target word unchanged.
- Force 2^ERR_CNT_W + 3 illegal accesses -> err_count saturates at all-ones.
- Loader read accepted, rst asserted the next cycle -> ld_rvalid = 0, err_count = 0; previously stored data still readable after rst deasserts.
